// File: rtl/uart_frame_sched_if.sv
// Sensor request/grant and UART TX handshake bundle
// used by the uart_frame_sched round-robin framer.
interface uart_frame_sched_if;
    logic [3:0]  req;
    logic [31:0] ch_data;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;

    modport master (
        input  req, ch_data, tx_busy,
        output grant, tx_start, tx_data
    );

    modport slave (
        output req, ch_data, tx_busy,
        input  grant, tx_start, tx_data
    );
endinterface

// File: rtl/uart_frame_sched.sv
// Periodic round-robin scheduler sharing one UART TX between
// four sensor channels; sends SYNC, channel ID, data, checksum.
module uart_frame_sched #(
    parameter int unsigned PERIOD = 50000,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    uart_frame_sched_if.master bus,
    output logic               frame_active,
    output logic [7:0]         overrun
);
    localparam int unsigned    PW   = $clog2(PERIOD);
    localparam logic [PW-1:0]  LAST = PW'(PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t        r_state;
    state_t        w_nstate;
    logic [PW-1:0] r_pace;
    logic [1:0]    r_rr;
    logic [1:0]    r_idx;
    logic [1:0]    r_ch;
    logic [7:0]    r_data;
    logic [3:0]    r_grant;
    logic [7:0]    r_tx_data;
    logic [7:0]    r_overrun;

    logic          w_tick;
    logic [1:0]    w_win;
    logic          w_has_win;
    logic          w_load;
    logic          w_adv;
    logic [1:0]    w_nidx;
    logic [7:0]    w_id;
    logic [7:0]    w_nbyte;
    logic          w_tx_start;
    logic          w_frame_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pace <= '0;
        end else if (!ena || r_pace == LAST) begin
            r_pace <= '0;
        end else begin
            r_pace <= r_pace + 1'b1;
        end
    end

    assign w_tick = ena && (r_pace == LAST);

    // Search starts one past the last winner and wraps.
    always_comb begin
        w_win     = r_rr;
        w_has_win = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_has_win && bus.req[r_rr + 2'(i)]) begin
                w_win     = r_rr + 2'(i);
                w_has_win = 1'b1;
            end
        end
    end

    assign w_load = (r_state == S_IDLE) && w_tick && w_has_win;
    assign w_adv  = (r_state == S_WAIT_LO) && !bus.tx_busy
                    && (r_idx != 2'd3);
    assign w_nidx = r_idx + 2'd1;
    assign w_id   = {6'b0, r_ch};

    always_comb begin
        case (w_nidx)
            2'd1:    w_nbyte = w_id;
            2'd2:    w_nbyte = r_data;
            default: w_nbyte = SYNC ^ w_id ^ r_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tick && w_has_win) w_nstate = S_ISSUE;
            end
            S_ISSUE: begin
                if (!bus.tx_busy) w_nstate = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (bus.tx_busy) w_nstate = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    w_nstate = (r_idx == 2'd3) ? S_IDLE : S_ISSUE;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_start     = (r_state == S_ISSUE) && !bus.tx_busy;
        w_frame_active = (r_state != S_IDLE);
    end

    // tx_data is loaded on entry to ISSUE so it is already valid
    // in the cycle tx_start fires and holds until the next byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr      <= 2'd3;
            r_idx     <= 2'd0;
            r_ch      <= 2'd0;
            r_data    <= 8'd0;
            r_grant   <= 4'd0;
            r_tx_data <= 8'd0;
            r_overrun <= 8'd0;
        end else begin
            r_grant <= 4'd0;
            if (w_load) begin
                r_ch      <= w_win;
                r_data    <= bus.ch_data[{w_win, 3'b000} +: 8];
                r_idx     <= 2'd0;
                r_rr      <= w_win;
                r_grant   <= 4'b0001 << w_win;
                r_tx_data <= SYNC;
            end else if (w_adv) begin
                r_idx     <= w_nidx;
                r_tx_data <= w_nbyte;
            end
            if (w_tick && (r_state != S_IDLE)
                && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end
    end

    assign bus.grant    = r_grant;
    assign bus.tx_start = w_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign frame_active = w_frame_active;
    assign overrun      = r_overrun;
endmodule

// File: tb/tb_uart_frame_sched.sv
// Randomised scoreboard bench for uart_frame_sched with a
// behavioural UART and a frame-level reference model.
module tb_uart_frame_sched;
    localparam int         PERIOD = 16;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       frame_active;
    logic [7:0] overrun;

    uart_frame_sched_if bus_if ();

    uart_frame_sched #(
        .PERIOD(PERIOD),
        .SYNC  (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .bus         (bus_if.master),
        .frame_active(frame_active),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // UART: busy rises the cycle after an accepted start, lasts u_b cycles
    int         u_b    = 1;
    logic       u_hold = 1'b0;
    int         u_cnt  = 0;
    int         u_acc  = 0;
    logic [7:0] u_byte = 8'd0;

    assign bus_if.tx_busy = u_hold || (u_cnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_cnt <= 0;
        end else if (bus_if.tx_start && !bus_if.tx_busy) begin
            u_cnt  <= u_b;
            u_acc  <= u_acc + 1;
            u_byte <= bus_if.tx_data;
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
        end
    end

    // Reference model: ticks every PERIOD enabled cycles, one frame
    // at a time, frame over once 4 bytes are accepted and UART idle.
    int         m_run   = 0;
    int         m_rr    = 3;
    bit         m_frame = 0;
    int         m_base  = 0;
    int         m_ovr   = 0;
    logic [3:0] m_gpend = 4'd0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        logic [3:0] eg;
        bit         tick;
        int         w;
        int         c;
        logic [7:0] b1;
        logic [7:0] b2;
        if (!rst_n) begin
            chk("rst_grant", bus_if.grant, 0);
            chk("rst_tx_start", bus_if.tx_start, 0);
            chk("rst_tx_data", bus_if.tx_data, 0);
            chk("rst_frame_active", frame_active, 0);
            chk("rst_overrun", overrun, 0);
            m_run   = 0;
            m_rr    = 3;
            m_frame = 0;
            m_ovr   = 0;
            m_gpend = 4'd0;
            m_base  = u_acc;
            exp_q.delete();
        end else begin
            eg      = m_gpend;
            m_gpend = 4'd0;
            if (bus_if.grant != 4'd0 || eg != 4'd0)
                chk("grant", bus_if.grant, eg);
            chk("frame_active", frame_active, m_frame);
            chk("overrun", overrun, m_ovr);
            if (u_cnt != 0)
                chk("tx_data_stable", bus_if.tx_data, u_byte);
            if (bus_if.tx_start) begin
                chk("start_while_busy", bus_if.tx_busy, 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_start: tx_data %0h at %0t",
                             bus_if.tx_data, $time);
                end else begin
                    chk("tx_byte", bus_if.tx_data, exp_q.pop_front());
                end
            end
            tick = ena && ((m_run % PERIOD) == PERIOD - 1);
            if (ena) m_run++;
            else m_run = 0;
            if (tick) begin
                if (m_frame) begin
                    if (m_ovr < 255) m_ovr++;
                end else if (bus_if.req != 4'd0) begin
                    w = -1;
                    for (int k = 1; k <= 4; k++) begin
                        c = (m_rr + k) % 4;
                        if (w < 0 && bus_if.req[c]) w = c;
                    end
                    m_rr    = w;
                    m_frame = 1;
                    m_base  = u_acc;
                    m_gpend = 4'b0001 << w;
                    b1      = 8'(w);
                    b2      = bus_if.ch_data[8*w +: 8];
                    exp_q.push_back(SYNC);
                    exp_q.push_back(b1);
                    exp_q.push_back(b2);
                    exp_q.push_back(SYNC ^ b1 ^ b2);
                end
            end
            if (m_frame && (u_acc - m_base) == 4 && !bus_if.tx_busy)
                m_frame = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_grant", bus_if.grant, 0);
        chk("async_tx_start", bus_if.tx_start, 0);
        chk("async_tx_data", bus_if.tx_data, 0);
        chk("async_frame_active", frame_active, 0);
        chk("async_overrun", overrun, 0);
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int i;
        ena    = 1'b0;
        u_hold = 1'b0;
        i      = 0;
        while (m_frame && i < 3000) begin
            cyc(1);
            i++;
        end
        chk("drain_done", m_frame, 0);
        cyc(2);
        chk("bytes_left", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        rst_n          = 1'b0;
        ena            = 1'b0;
        bus_if.req     = 4'd0;
        bus_if.ch_data = 32'd0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // single frame from ch2
        u_b            = 10;
        bus_if.req     = 4'b0100;
        bus_if.ch_data = 32'h003C_0000;
        ena            = 1'b1;
        cyc(PERIOD + 2);
        drain();

        // round robin across all four channels
        do_reset();
        u_b            = 1;
        bus_if.req     = 4'b1111;
        bus_if.ch_data = $urandom;
        ena            = 1'b1;
        cyc(5 * PERIOD);
        drain();

        // empty ticks, then ch1
        do_reset();
        u_b        = 2;
        bus_if.req = 4'd0;
        ena        = 1'b1;
        cyc(3 * PERIOD);
        bus_if.req     = 4'b0010;
        bus_if.ch_data = $urandom;
        cyc(PERIOD + 20);
        drain();

        // slow UART, then a stuck UART to saturate overrun
        do_reset();
        u_b            = 100;
        bus_if.req     = 4'b0001;
        bus_if.ch_data = $urandom;
        ena            = 1'b1;
        cyc(1000);
        u_hold = 1'b1;
        cyc(4300);
        chk("overrun_saturated", overrun, 255);
        drain();

        // UART busy when the frame starts
        do_reset();
        u_b            = 3;
        u_hold         = 1'b1;
        bus_if.req     = 4'b0001;
        bus_if.ch_data = $urandom;
        ena            = 1'b1;
        cyc(PERIOD + 10);
        chk("held_no_start", bus_if.tx_start, 0);
        ena    = 1'b0;
        u_hold = 1'b0;
        cyc(20);
        drain();

        // reset while byte2 is on the line
        do_reset();
        u_b            = 8;
        bus_if.req     = 4'b1000;
        bus_if.ch_data = $urandom;
        ena            = 1'b1;
        i              = 0;
        while (!((u_acc - m_base) == 3 && u_cnt != 0) && i < 300) begin
            cyc(1);
            i++;
        end
        chk("reached_byte2", i < 300, 1);
        do_reset();
        cyc(PERIOD + 30);

        // ena dropped mid-frame, then re-enabled
        i = 0;
        while (!m_frame && i < 3 * PERIOD) begin
            cyc(1);
            i++;
        end
        chk("frame_before_ena_drop", m_frame, 1);
        cyc(3);
        drain();
        ena = 1'b1;
        cyc(PERIOD + 30);
        drain();

        // random traffic
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            bus_if.req     = 4'($urandom_range(0, 15));
            bus_if.ch_data = $urandom;
            u_b            = $urandom_range(1, 12);
            ena            = 1'b1;
            for (int n = $urandom_range(20, 120); n > 0; n--) begin
                if ($urandom_range(0, 7) == 0)
                    bus_if.req = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0)
                    bus_if.ch_data = $urandom;
                if ($urandom_range(0, 19) == 0)
                    ena = ~ena;
                cyc(1);
            end
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
